icache: RTL

//  - Direct-mapped, one-word-per-block instruction cache.
//  - Responder end of the datapath instruction-fetch port: serves imemREN/imemaddr

---
 rtl/icache_pkg.sv | 35 +++
 rtl/icache.sv | 64 ++++++
 2 files changed

// File: rtl/icache_pkg.sv
// Types and geometry shared by the direct-mapped instruction cache.
// Address split is tag | index | byte offset, one 32-bit word per frame.
package icache_pkg;
  localparam int NSETS = 16;
  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 32 - 2 - IDX_W;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            data;
  } icache_frame_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } icachef_t;

  typedef enum logic {IDLE, FETCH} icache_state_t;

  function automatic logic [IDX_W-1:0] idx_of(input word_t a);
    icachef_t f;
    f = a;
    return f.idx;
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input word_t a);
    icachef_t f;
    f = a;
    return f.tag;
  endfunction
endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache: 0-cycle hit, blocking miss
// that fills from the memory controller and holds the datapath off via ihit=0.
module icache
  import icache_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  icache_frame_t [NSETS-1:0] r_frames;
  icache_state_t             r_state;
  word_t                     r_miss_addr;

  icache_frame_t w_frame;
  logic          w_hit;

  always_comb begin
    w_frame  = r_frames[idx_of(imemaddr)];
    w_hit    = imemREN && (r_state == IDLE) && w_frame.valid &&
               (w_frame.tag == tag_of(imemaddr));
    ihit     = w_hit;
    imemload = w_frame.data;
    iREN     = (r_state == FETCH);
    iaddr    = (r_state == FETCH) ? r_miss_addr : '0;
  end

  // Tag and data need no reset; only valid bits are cleared so a reset mid-fill
  // leaves no partially written frame visible.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= '0;
      for (int i = 0; i < NSETS; i++) r_frames[i].valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (imemREN && !w_hit) begin
            r_state     <= FETCH;
            r_miss_addr <= {imemaddr[31:2], 2'b00};
          end
        end
        FETCH: begin
          // Fill always targets the latched miss address, even after a redirect.
          if (!iwait) begin
            r_frames[idx_of(r_miss_addr)] <= '{valid: 1'b1,
                                               tag:   tag_of(r_miss_addr),
                                               data:  iload};
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
